// File: rtl/custom_buff_step_sequencer_pkg.sv
// Shared constants and FSM encoding for the buffer-schedule step sequencer.
package custom_buff_step_sequencer_pkg;

    localparam int CNT_W     = 5;
    localparam int LAST_STEP = 25;
    localparam int NUM_BUFF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/custom_buff_step_sequencer.sv
// Step sequencer: walks step_cnt 0..LAST_STEP once per start, issuing read
// requests for the buffers the external decoder marks as used at each step
// and holding the step until every requested buffer has acknowledged.
module custom_buff_step_sequencer
    import custom_buff_step_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [CNT_W-1:0]    step_cnt,
    input  logic [NUM_BUFF-1:0] buff_use,
    output logic [NUM_BUFF-1:0] rd_req,
    input  logic [NUM_BUFF-1:0] rd_ack,
    output logic                step_valid,
    output logic                busy,
    output logic                done
);

    seq_state_t          state;
    seq_state_t          state_nxt;
    logic [NUM_BUFF-1:0] pending;
    logic [NUM_BUFF-1:0] pend_ret;
    logic                last_step;
    logic                step_fin;

    // Only acks on currently requested bits retire a pending buffer; several
    // buffers may retire in the same cycle.
    assign pend_ret  = pending & ~(rd_ack & rd_req);
    assign last_step = (step_cnt == CNT_W'(LAST_STEP));

    // Current step is serviced: empty mask in ISSUE, or last ack seen in WAIT.
    assign step_fin = ((state == ST_ISSUE) && (buff_use == '0)) ||
                      ((state == ST_WAIT)  && (pend_ret == '0));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a finished step either moves to the next ISSUE or,
    // after LAST_STEP, to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (buff_use != '0) begin
                    state_nxt = ST_WAIT;
                end else if (last_step) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (pend_ret == '0) begin
                    state_nxt = last_step ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs: step_valid is same-cycle with the completing condition, so no
    // bubble is added between steps.
    always_comb begin
        step_valid = step_fin;
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
    end

    // Step counter, pending mask and registered read requests. rd_req only
    // drops bits that have been acked, so a still-pending bit never toggles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
            pending  <= '0;
            rd_req   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pending <= '0;
                    rd_req  <= '0;
                    if (start) begin
                        step_cnt <= '0;
                    end
                end
                ST_ISSUE: begin
                    pending <= buff_use;
                    if (buff_use != '0) begin
                        rd_req <= buff_use;
                    end else if (!last_step) begin
                        step_cnt <= step_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    pending <= pend_ret;
                    rd_req  <= pend_ret;
                    if ((pend_ret == '0) && !last_step) begin
                        step_cnt <= step_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    step_cnt <= '0;
                    pending  <= '0;
                    rd_req   <= '0;
                end
                default: begin
                    step_cnt <= '0;
                    pending  <= '0;
                    rd_req   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_custom_buff_step_sequencer.sv
// Directed bench for the buffer-schedule step sequencer, with a small step
// decoder model closing the step_cnt -> buff_use loop.
module tb_custom_buff_step_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] step_cnt;
    logic [3:0] buff_use;
    logic [3:0] rd_req;
    logic [3:0] rd_ack;
    logic       step_valid;
    logic       busy;
    logic       done;

    int nchecks;
    int nerrors;

    custom_buff_step_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .step_cnt   (step_cnt),
        .buff_use   (buff_use),
        .rd_req     (rd_req),
        .rd_ack     (rd_ack),
        .step_valid (step_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step decoder: steps 0-4 use no buffer, step 5 uses buffer 3,
    // step 12 uses buffers 1-3, every other step one rotating buffer.
    function automatic logic [3:0] decode(input logic [4:0] s);
        if (s < 5'd5)        return 4'b0000;
        else if (s == 5'd5)  return 4'b1000;
        else if (s == 5'd12) return 4'b1110;
        else                 return 4'b0001 << s[1:0];
    endfunction

    always_comb buff_use = decode(step_cnt);

    task automatic start_seq();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Acks everything until the sequencer enters ISSUE at target; returns at
    // negedge+1 of that cycle with rd_ack cleared.
    task automatic advance_to(input logic [4:0] target);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (step_cnt == target) begin
                rd_ack = 4'b0000;
                found  = 1'b1;
                break;
            end
            rd_ack = 4'b1111;
            @(negedge clk);
        end
        nchecks++;
        if (!found) begin
            nerrors++;
            $display("FAIL advance_to: step %0d not reached, step_cnt=%0d", target, step_cnt);
        end
    endtask

    // Acks everything until done, then checks the return to IDLE.
    task automatic finish_run(input string tag);
        bit found;
        found  = 1'b0;
        rd_ack = 4'b1111;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        rd_ack = 4'b0000;
        nchecks++;
        if (!found) begin
            nerrors++;
            $display("FAIL %s_done: done never seen, required 1", tag);
        end
        @(negedge clk);
        #1;
        nchecks++;
        if (busy !== 1'b0 || step_cnt !== 5'd0) begin
            nerrors++;
            $display("FAIL %s_idle: busy=%b step_cnt=%0d, required busy=0 step_cnt=0", tag, busy, step_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rd_ack = 4'b0000;
        repeat (2) @(negedge clk);
        #1;
        nchecks++;
        if ({step_cnt, rd_req, step_valid, busy, done} !== 12'd0) begin
            nerrors++;
            $display("FAIL reset_outputs: step_cnt=%0d rd_req=%b sv=%b busy=%b done=%b, required all 0",
                     step_cnt, rd_req, step_valid, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_run();
        int pulses, cycles;
        bit got_done;
        pulses = 0; cycles = 0; got_done = 1'b0;
        rd_ack = 4'b1111;
        start_seq();
        for (int i = 0; i < 200; i++) begin
            #1;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (step_valid) begin
                nchecks++;
                if (step_cnt !== 5'(pulses)) begin
                    nerrors++;
                    $display("FAIL full_step_order: step_cnt=%0d, required %0d", step_cnt, pulses);
                end
                pulses++;
            end
            nchecks++;
            if (busy !== 1'b1) begin
                nerrors++;
                $display("FAIL full_busy: busy=%b, required 1", busy);
            end
            cycles++;
            @(negedge clk);
        end
        nchecks++;
        if (!got_done) begin
            nerrors++;
            $display("FAIL full_done: done not seen, required 1");
        end
        nchecks++;
        if (pulses != 26) begin
            nerrors++;
            $display("FAIL full_pulses: got %0d step_valid, required 26", pulses);
        end
        nchecks++;
        if (cycles != 47) begin
            nerrors++;
            $display("FAIL full_cycles: got %0d cycles, required 47", cycles);
        end
        @(negedge clk);
        #1;
        nchecks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            nerrors++;
            $display("FAIL full_after_done: done=%b busy=%b, required 0 0", done, busy);
        end
        rd_ack = 4'b0000;
    endtask

    task automatic test_multi_ack();
        logic [3:0] acks [3];
        logic [3:0] reqs [3];
        acks = '{4'b0010, 4'b0100, 4'b1000};
        reqs = '{4'b1110, 4'b1100, 4'b1000};
        start_seq();
        advance_to(5'd12);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rd_ack = acks[k];
            #1;
            nchecks++;
            if (rd_req !== reqs[k] || step_cnt !== 5'd12) begin
                nerrors++;
                $display("FAIL multi_req%0d: rd_req=%b step_cnt=%0d, required %b 12", k, rd_req, step_cnt, reqs[k]);
            end
            nchecks++;
            if (step_valid !== (k == 2)) begin
                nerrors++;
                $display("FAIL multi_sv%0d: step_valid=%b, required %b", k, step_valid, (k == 2));
            end
        end
        @(negedge clk);
        rd_ack = 4'b0000;
        #1;
        nchecks++;
        if (rd_req !== 4'b0000 || step_cnt !== 5'd13) begin
            nerrors++;
            $display("FAIL multi_advance: rd_req=%b step_cnt=%0d, required 0000 13", rd_req, step_cnt);
        end
        finish_run("multi");
    endtask

    task automatic test_spurious_ack();
        start_seq();
        advance_to(5'd5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rd_ack = 4'b0111;
            #1;
            nchecks++;
            if (step_valid !== 1'b0 || rd_req !== 4'b1000 || step_cnt !== 5'd5) begin
                nerrors++;
                $display("FAIL spur%0d: sv=%b rd_req=%b step_cnt=%0d, required 0 1000 5", k, step_valid, rd_req, step_cnt);
            end
        end
        @(negedge clk);
        rd_ack = 4'b1000;
        #1;
        nchecks++;
        if (step_valid !== 1'b1) begin
            nerrors++;
            $display("FAIL spur_release: step_valid=%b, required 1", step_valid);
        end
        @(negedge clk);
        rd_ack = 4'b0000;
        #1;
        nchecks++;
        if (step_cnt !== 5'd6) begin
            nerrors++;
            $display("FAIL spur_advance: step_cnt=%0d, required 6", step_cnt);
        end
        finish_run("spur");
    endtask

    task automatic test_start_held();
        int pulses;
        bit got_done;
        pulses = 0; got_done = 1'b0;
        rd_ack = 4'b1111;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (step_valid) pulses++;
        end
        nchecks++;
        if (!got_done || pulses != 26) begin
            nerrors++;
            $display("FAIL held_first: done=%b pulses=%0d, required 1 26", got_done, pulses);
        end
        @(negedge clk);
        #1;
        nchecks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            nerrors++;
            $display("FAIL held_idle: busy=%b done=%b, required 0 0", busy, done);
        end
        @(negedge clk);
        #1;
        nchecks++;
        if (busy !== 1'b1 || step_cnt !== 5'd0) begin
            nerrors++;
            $display("FAIL held_restart: busy=%b step_cnt=%0d, required 1 0", busy, step_cnt);
        end
        start = 1'b0;
        finish_run("held");
    endtask

    task automatic test_reset_mid_wait();
        start_seq();
        advance_to(5'd17);
        @(negedge clk);
        #1;
        nchecks++;
        if (rd_req !== 4'b0010) begin
            nerrors++;
            $display("FAIL rst_pre: rd_req=%b, required 0010", rd_req);
        end
        #1;
        rst = 1'b1;
        #1;
        nchecks++;
        if (rd_req !== 4'b0000 || step_cnt !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
            nerrors++;
            $display("FAIL rst_async: rd_req=%b step_cnt=%0d busy=%b done=%b, required 0000 0 0 0",
                     rd_req, step_cnt, busy, done);
        end
        @(negedge clk);
        #1;
        nchecks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            nerrors++;
            $display("FAIL rst_hold: done=%b busy=%b, required 0 0", done, busy);
        end
        rst = 1'b0;
        start_seq();
        #1;
        nchecks++;
        if (step_cnt !== 5'd0 || busy !== 1'b1) begin
            nerrors++;
            $display("FAIL rst_rerun: step_cnt=%0d busy=%b, required 0 1", step_cnt, busy);
        end
        finish_run("rst");
    endtask

    task automatic test_idle();
        start = 1'b0;
        rd_ack = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            nchecks++;
            if ({step_cnt, rd_req, step_valid, busy, done} !== 12'd0) begin
                nerrors++;
                $display("FAIL idle%0d: step_cnt=%0d rd_req=%b sv=%b busy=%b done=%b, required all 0",
                         i, step_cnt, rd_req, step_valid, busy, done);
            end
        end
    endtask

    initial begin
        nchecks = 0;
        nerrors = 0;
        test_reset();
        test_full_run();
        test_multi_ack();
        test_spurious_ack();
        test_start_held();
        test_reset_mid_wait();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
